// File: rtl/audio_i2s_stereo_rx.sv
// rtl/audio_i2s_stereo_rx.sv - I2S stereo ADC receiver packing {left, right} samples
module audio_i2s_stereo_rx #(
    parameter int CH_BITS = 16
) (
    input  logic                   aud_bclk,
    input  logic                   rst_n,
    input  logic                   rx_en,
    input  logic                   aud_lrc,
    input  logic                   aud_adcdat,
    output logic                   aud_rx_done,
    output logic [2*CH_BITS-1:0]   aud_adc_data,
    output logic                   frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 lrc_d0;
    logic [5:0]           cnt;
    logic [CH_BITS-1:0]   shift_q;
    logic [CH_BITS-1:0]   shift_next;
    logic [CH_BITS-1:0]   left_q;
    logic                 left_valid;
    logic                 pend_q;

    logic                 fall, rise, lrc_edge;
    logic                 bit_take, last_bit, short_ch;
    logic                 left_load, left_clr, pend_d, err_d;

    assign fall     = lrc_d0 & ~aud_lrc;
    assign rise     = ~lrc_d0 & aud_lrc;
    assign lrc_edge = fall | rise;

    // The bit sampled on an edge cycle is the previous channel's LSB, so it never shifts in.
    assign bit_take = !lrc_edge && (cnt < 6'(CH_BITS));
    assign last_bit = !lrc_edge && (cnt == 6'(CH_BITS - 1));
    assign short_ch = cnt < 6'(CH_BITS);

    generate
        if (CH_BITS == 1) begin : g_shift_one
            assign shift_next = aud_adcdat;
        end else begin : g_shift_many
            assign shift_next = {shift_q[CH_BITS-2:0], aud_adcdat};
        end
    endgenerate

    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        left_load = 1'b0;
        left_clr  = 1'b0;
        pend_d    = 1'b0;
        err_d     = 1'b0;
        if (!rx_en) begin
            state_d  = IDLE;
            left_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_d = LEFT;
                    end
                end
                LEFT, RIGHT: begin
                    if (lrc_edge) begin
                        if (short_ch) begin
                            err_d    = 1'b1;
                            left_clr = 1'b1;
                        end
                        state_d = fall ? LEFT : RIGHT;
                    end else if (last_bit) begin
                        if (state_q == LEFT) begin
                            left_load = 1'b1;
                        end else if (left_valid) begin
                            pend_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_d0  <= 1'b0;
            cnt     <= 6'd0;
            shift_q <= '0;
        end else begin
            lrc_d0 <= aud_lrc;
            if (lrc_edge) begin
                cnt <= 6'd0;
            end else if (cnt != 6'd63) begin
                cnt <= cnt + 6'd1;
            end
            if (bit_take) begin
                shift_q <= shift_next;
            end
        end
    end

    // A left word is consumed by exactly one right word, so a stray second right channel cannot reuse it.
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            left_q     <= '0;
            left_valid <= 1'b0;
        end else if (left_clr) begin
            left_q     <= '0;
            left_valid <= 1'b0;
        end else if (left_load) begin
            left_q     <= shift_next;
            left_valid <= 1'b1;
        end else if (pend_d) begin
            left_valid <= 1'b0;
        end
    end

    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= 1'b0;
            aud_rx_done  <= 1'b0;
            aud_adc_data <= '0;
            frame_err    <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            frame_err   <= err_d;
            aud_rx_done <= pend_q && rx_en;
            if (pend_q && rx_en) begin
                aud_adc_data <= {left_q, shift_q};
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_stereo_rx.sv
// tb/tb_audio_i2s_stereo_rx.sv - directed table-driven bench for audio_i2s_stereo_rx
module tb_audio_i2s_stereo_rx;

    logic        aud_bclk = 1'b0;
    logic        rst_n;
    logic        rx_en;
    logic        aud_lrc;
    logic        aud_adcdat;
    logic        aud_rx_done;
    logic [31:0] aud_adc_data;
    logic        frame_err;

    audio_i2s_stereo_rx #(.CH_BITS(16)) dut (
        .aud_bclk     (aud_bclk),
        .rst_n        (rst_n),
        .rx_en        (rx_en),
        .aud_lrc      (aud_lrc),
        .aud_adcdat   (aud_adcdat),
        .aud_rx_done  (aud_rx_done),
        .aud_adc_data (aud_adc_data),
        .frame_err    (frame_err)
    );

    always #5 aud_bclk = ~aud_bclk;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          rise_cyc = 0;
    logic        lrc_prev = 1'b0;
    int          err_cnt = 0;
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          obs_lat[$];
    logic        pend = 1'b0;

    always @(posedge aud_bclk) begin
        cyc = cyc + 1;
        if (!lrc_prev && aud_lrc) rise_cyc = cyc;
        lrc_prev = aud_lrc;
        #1;
        if (aud_rx_done) begin
            obs_data.push_back(aud_adc_data);
            obs_cyc.push_back(cyc);
            obs_lat.push_back(cyc - rise_cyc);
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic bit_at(input logic [31:0] w, input int k);
        return (k >= 1 && k <= 32) ? w[32-k] : 1'b0;
    endfunction

    task automatic send_ch(input logic l, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aud_bclk);
            aud_lrc    = l;
            aud_adcdat = (i == 0) ? pend : bit_at(w, i);
        end
        pend = bit_at(w, n);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int ln, input int rn);
        send_ch(1'b0, l, ln);
        send_ch(1'b1, r, rn);
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_cyc.delete();
        obs_lat.delete();
        err_cnt = 0;
    endtask

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          ln;
        int          rn;
        int          exp_strobes;
        logic [31:0] exp_data;
        int          exp_errs;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] last_data;

    initial begin
        vecs[0] = '{32'hA5A51234, 32'h3C3C5678, 32, 32, 1, 32'hA5A53C3C, 0};
        vecs[1] = '{32'hFFFF0000, 32'h0000FFFF, 32, 32, 1, 32'hFFFF0000, 0};
        vecs[2] = '{32'h80000001, 32'h00018000, 32, 32, 1, 32'h80000001, 0};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 10, 32, 0, 32'h0,        1};
        vecs[4] = '{32'hDEADBEEF, 32'hCAFEF00D, 32, 32, 1, 32'hDEADCAFE, 0};
        vecs[5] = '{32'h0001FFFF, 32'hFFFE0000, 17, 32, 1, 32'h0001FFFE, 0};
        vecs[6] = '{32'h5555AAAA, 32'h11112222, 16, 32, 0, 32'h0,        1};
        vecs[7] = '{32'hC0DE0000, 32'hBEEF4321, 70, 32, 1, 32'hC0DEBEEF, 0};

        rst_n      = 1'b0;
        rx_en      = 1'b1;
        aud_lrc    = 1'b1;
        aud_adcdat = 1'b0;
        repeat (3) @(negedge aud_bclk);
        check("reset done", 64'(aud_rx_done), 64'd0);
        check("reset data", 64'(aud_adc_data), 64'd0);
        check("reset err", 64'(frame_err), 64'd0);
        rst_n = 1'b1;

        // Stream begins mid-right: nothing may come out until a full left+right pair.
        clear_obs();
        send_ch(1'b1, 32'hFFFFFFFF, 32);
        check("preamble strobes", 64'(obs_data.size()), 64'd0);
        check("preamble errs", 64'(err_cnt), 64'd0);

        last_data = 32'h0;
        for (int v = 0; v < 8; v++) begin
            clear_obs();
            send_frame(vecs[v].l, vecs[v].r, vecs[v].ln, vecs[v].rn);
            check($sformatf("vec%0d strobes", v), 64'(obs_data.size()), 64'(vecs[v].exp_strobes));
            check($sformatf("vec%0d errs", v), 64'(err_cnt), 64'(vecs[v].exp_errs));
            if (vecs[v].exp_strobes == 1 && obs_data.size() == 1) begin
                check($sformatf("vec%0d data", v), 64'(obs_data[0]), 64'(vecs[v].exp_data));
                check($sformatf("vec%0d latency", v), 64'(obs_lat[0]), 64'd17);
                last_data = vecs[v].exp_data;
            end else begin
                check($sformatf("vec%0d data held", v), 64'(aud_adc_data), 64'(last_data));
            end
        end

        // rx_en drops mid-right, returns mid-left of the following frame.
        clear_obs();
        fork
            send_frame(32'h11112222, 32'h33334444, 32, 32);
            begin
                repeat (40) @(negedge aud_bclk);
                rx_en = 1'b0;
            end
        join
        check("rxen drop strobes", 64'(obs_data.size()), 64'd0);
        check("rxen drop data held", 64'(aud_adc_data), 64'(last_data));
        clear_obs();
        fork
            send_frame(32'h55556666, 32'h77778888, 32, 32);
            begin
                repeat (10) @(negedge aud_bclk);
                rx_en = 1'b1;
            end
        join
        check("rxen mid-left strobes", 64'(obs_data.size()), 64'd0);
        check("rxen mid-left data held", 64'(aud_adc_data), 64'(last_data));
        clear_obs();
        send_frame(32'h9999AAAA, 32'hBBBBCCCC, 32, 32);
        check("rxen resume strobes", 64'(obs_data.size()), 64'd1);
        if (obs_data.size() == 1) check("rxen resume data", 64'(obs_data[0]), 64'h9999BBBB);
        check("rxen errs", 64'(err_cnt), 64'd0);

        // Asynchronous reset for three cycles mid-left.
        clear_obs();
        fork
            send_frame(32'h12340000, 32'h56780000, 32, 32);
            begin
                repeat (10) @(negedge aud_bclk);
                rst_n = 1'b0;
                #1;
                check("midreset done", 64'(aud_rx_done), 64'd0);
                check("midreset data", 64'(aud_adc_data), 64'd0);
                check("midreset err", 64'(frame_err), 64'd0);
                repeat (3) @(negedge aud_bclk);
                rst_n = 1'b1;
            end
        join
        check("midreset frame strobes", 64'(obs_data.size()), 64'd0);
        clear_obs();
        send_frame(32'hFEDC0000, 32'hBA980000, 32, 32);
        check("post reset strobes", 64'(obs_data.size()), 64'd1);
        if (obs_data.size() == 1) check("post reset data", 64'(obs_data[0]), 64'hFEDCBA98);
        check("post reset errs", 64'(err_cnt), 64'd0);

        // 200 back-to-back frames into a FIFO model.
        clear_obs();
        for (int i = 0; i < 200; i++) begin
            send_frame({16'(i), 16'h1234}, {~16'(i), 16'h5678}, 32, 32);
        end
        check("burst strobes", 64'(obs_data.size()), 64'd200);
        check("burst errs", 64'(err_cnt), 64'd0);
        for (int j = 0; j < obs_data.size() && j < 200; j++) begin
            check($sformatf("burst data %0d", j), 64'(obs_data[j]), 64'({16'(j), ~16'(j)}));
            if (j > 0) check($sformatf("burst spacing %0d", j), 64'(obs_cyc[j] - obs_cyc[j-1]), 64'd64);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
